// File: rtl/pipeline_mem_reader_pkg.sv
// rtl/pipeline_mem_reader_pkg.sv - shared defaults, result record and sizing helper for the memory reader
package pipeline_mem_reader_pkg;

    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_RD_W       = 4;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [DEF_RD_W-1:0]   rd;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } mem_result_t;

    // Occupancy counter must hold the value DEPTH itself, hence the extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mem_reader_fifo.sv
// rtl/mem_reader_fifo.sv - in-order response FIFO with occupancy count, pointers wrap modulo DEPTH
module mem_reader_fifo
    import pipeline_mem_reader_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int W     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [W-1:0]                push_data,
    input  logic                        pop,
    output logic                        head_valid,
    output logic [W-1:0]                head_data,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        do_push  = push && !full;
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared so the head fields read as zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_valid = (count_q != '0);
    assign head_data  = mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/pipeline_mem_reader.sv
// rtl/pipeline_mem_reader.sv - credit-managed 3-stage load pipeline with register write-back and response FIFO (MEM_READER_STATS_EN adds rd_count)
module pipeline_mem_reader
    import pipeline_mem_reader_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_W       = DEF_RD_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [RD_W-1:0]   req_rd,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rf_we,
    output logic [RD_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
`ifdef MEM_READER_STATS_EN
    output logic [15:0]       rd_count,
`endif
    output logic [RD_W-1:0]   resp_rd,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [DATA_W-1:0] resp_data
);

    localparam int CNT_W  = cnt_width(FIFO_DEPTH);
    localparam int CRED_W = CNT_W + 1;

    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } res_t;

    logic              s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic [RD_W-1:0]   s1_rd_q, s1_rd_d;
    logic              s2_valid_q, s2_valid_d;
    logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
    logic [RD_W-1:0]   s2_rd_q, s2_rd_d;
    logic              wb_valid_q, wb_valid_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic [CNT_W-1:0]  fifo_count;
    logic [CRED_W-1:0] credits;
    logic              accept;
    logic              pop;
    res_t              push_res;
    res_t              head_res;

    // Stage 1 drives the memory, stage 2 waits for read data; both hold a credit
    // until the result lands in the FIFO on the same edge as the write-back.
    always_comb begin
        credits    = CRED_W'(fifo_count) + CRED_W'(s1_valid_q) + CRED_W'(s2_valid_q);
        req_ready  = !rst && (credits < CRED_W'(FIFO_DEPTH));
        accept     = req_valid && req_ready;
        pop        = resp_valid && resp_ready;

        s1_valid_d = accept;
        s1_addr_d  = accept ? req_addr : s1_addr_q;
        s1_rd_d    = accept ? req_rd : s1_rd_q;

        s2_valid_d = s1_valid_q;
        s2_addr_d  = s1_valid_q ? s1_addr_q : s2_addr_q;
        s2_rd_d    = s1_valid_q ? s1_rd_q : s2_rd_q;

        push_res   = '{rd: s2_rd_q, addr: s2_addr_q, data: mem_rdata};
        wb_valid_d = s2_valid_q;
        wb_rd_d    = s2_valid_q ? s2_rd_q : wb_rd_q;
        wb_data_d  = s2_valid_q ? mem_rdata : wb_data_q;
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_rd_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_rd_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            s1_rd_q    <= s1_rd_d;
            s2_valid_q <= s2_valid_d;
            s2_addr_q  <= s2_addr_d;
            s2_rd_q    <= s2_rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    mem_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(res_t))
    ) u_fifo (
        .clk        (clk1),
        .rst        (rst),
        .push       (s2_valid_q),
        .push_data  (push_res),
        .pop        (pop),
        .head_valid (resp_valid),
        .head_data  (head_res),
        .count      (fifo_count)
    );

    assign mem_rd_en = s1_valid_q;
    assign mem_addr  = s1_addr_q;
    assign rf_we     = wb_valid_q;
    assign rf_waddr  = wb_rd_q;
    assign rf_wdata  = wb_data_q;
    assign resp_rd   = head_res.rd;
    assign resp_addr = head_res.addr;
    assign resp_data = head_res.data;

`ifdef MEM_READER_STATS_EN
    logic [15:0] rd_count_q;

    always_ff @(posedge clk1) begin
        if (rst)      rd_count_q <= 16'd0;
        else if (pop) rd_count_q <= rd_count_q + 16'd1;
    end

    assign rd_count = rd_count_q;
`endif

endmodule

// File: doc/pipeline_mem_reader.md
PIPELINE_MEM_READER -- requirements
Module: pipeline_mem_reader

Interface
REQ-001 Parameter ADDR_W, default 8: memory address width (256 words).
REQ-002 Parameter DATA_W, default 16: memory and register word width.
REQ-003 Parameter RD_W, default 4: destination register index width (16 registers).
REQ-004 Parameter FIFO_DEPTH, default 4: response FIFO entries; power of two, minimum 2.
REQ-005 clk1  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  load request present.
REQ-008 req_ready  out  1  load request may be accepted.
REQ-009 req_addr  in  ADDR_W  memory word address to read.
REQ-010 req_rd  in  RD_W  destination register index.
REQ-011 mem_rd_en  out  1  memory read strobe.
REQ-012 mem_addr  out  ADDR_W  memory read address.
REQ-013 mem_rdata  in  DATA_W  read data, valid exactly one cycle after mem_rd_en.
REQ-014 rf_we  out  1  register-bank write strobe, one-cycle pulse.
REQ-015 rf_waddr  out  RD_W  register-bank write index.
REQ-016 rf_wdata  out  DATA_W  register-bank write data.
REQ-017 resp_valid  out  1  FIFO head valid.
REQ-018 resp_ready  in  1  consumer accepts FIFO head.
REQ-019 resp_rd, resp_addr, resp_data  out  RD_W/ADDR_W/DATA_W  FIFO head fields.

Function
REQ-020 A request SHALL be accepted in cycle N iff req_valid and req_ready are both high at the rising edge ending N.
REQ-021 Cycle N+1: mem_rd_en SHALL be 1 with mem_addr = accepted req_addr; otherwise mem_rd_en SHALL be 0.
REQ-022 Edge ending N+2: mem_rdata, rd and addr SHALL be registered together as one result.
REQ-023 Cycle N+3: rf_we SHALL pulse with rf_waddr/rf_wdata = that result, and the result SHALL be present in the FIFO (resp_valid high if it is the head).
REQ-024 Accept-to-resp_valid latency SHALL be exactly 3 cycles when the FIFO is empty.
REQ-025 credits = in-flight results (stages 1-2) + FIFO occupancy; req_ready SHALL be 1 iff credits < FIFO_DEPTH, from registered state only (no combinational path from req_valid or resp_ready).
REQ-026 Simultaneous accept and FIFO pop SHALL leave credits unchanged; sustained throughput SHALL be one request per cycle while resp_ready is held high.
REQ-027 The FIFO SHALL be strictly in order; pop when resp_valid and resp_ready; resp_* SHALL stay stable while resp_valid is high and resp_ready is low.
REQ-028 Register write-back (rf_we) SHALL never be back-pressured; resp_ready affects only the FIFO and req_ready.
REQ-029 Push into a full FIFO SHALL be impossible by construction; pop from an empty FIFO SHALL be ignored.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-031 While rst is high: req_ready=0, mem_rd_en=0, rf_we=0, resp_valid=0, credits=0, FIFO empty, all data outputs 0.
REQ-032 Reset mid-operation SHALL discard all in-flight and buffered results; no rf_we pulse SHALL occur for requests accepted before reset.
REQ-033 req_ready SHALL be 1 in the first cycle after rst is deasserted.

Configuration
REQ-034 With MEM_READER_STATS_EN defined: output rd_count (16 bits) SHALL count FIFO pops, reset to 0, wrapping 0xFFFF -> 0x0000.
REQ-035 Without MEM_READER_STATS_EN: rd_count port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-036 Package pipeline_mem_reader_pkg SHALL hold ADDR_W/DATA_W/RD_W/FIFO_DEPTH defaults and result struct (rd, addr, data).
REQ-037 Response FIFO SHALL be sub-module mem_reader_fifo (parameterised depth, count output).

Verification
REQ-038 Single load: addr=0x10 (mem=0xBEEF), rd=3, resp_ready=1 -> mem_rd_en at N+1, rf_we with (3,0xBEEF) and resp_valid at N+3.
REQ-039 Streaming: 8 back-to-back loads addr 0..7, resp_ready=1 -> req_ready never drops, 8 responses in order on consecutive cycles.
REQ-040 Backpressure: resp_ready=0, continuous requests -> exactly 4 accepted, req_ready=0 after; resp_ready=1 drains in order, req_ready returns.
REQ-041 Simultaneous push/pop at FIFO occupancy 3 -> occupancy stays 3, no loss or duplication.
REQ-042 rst asserted cycle after accept at addr=0x20 -> no rf_we, no resp_valid afterwards; req_ready=1 after release.
REQ-043 MEM_READER_STATS_EN: preload rd_count to 0xFFFE via 65534 pops, 2 more pops -> rd_count = 0x0000.
